// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, preload table and latency bound for dmem_sync
package dmem_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
  localparam int RD_LAT_MAX = 4;
  localparam logic [9:0][63:0] PRELOAD_TBL = {
    64'd36, 64'd32, 64'd28, 64'd24, 64'd20, 64'd6, 64'd12, 64'd8, 64'd3, 64'd2
  };
  function automatic logic [63:0] preload_word(input int i);
    return (i >= 0 && i < 10) ? PRELOAD_TBL[i] : 64'd0;
  endfunction
endpackage

// File: rtl/dmem_rsp_timer.sv
// dmem_rsp_timer: IDLE/WAIT/RESP sequencer that spaces responses RD_LAT cycles after acceptance
module dmem_rsp_timer
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_valid,
  output logic o_req_ready,
  output logic o_rsp_valid,
  output logic o_accept,
  output logic o_enter_resp
);
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  assign o_req_ready  = r_state == ST_IDLE;
  assign o_rsp_valid  = r_state == ST_RESP;
  assign o_accept     = o_req_ready && i_req_valid && !reset;
  assign o_enter_resp = (o_accept && RD_LAT == 1) || (r_state == ST_WAIT && r_cnt == CNT_W'(1));
  // Countdown from RD_LAT-1 in WAIT; RESP lasts one cycle then back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (o_accept) begin
      r_state <= (RD_LAT == 1) ? ST_RESP : ST_WAIT;
      r_cnt   <= CNT_W'(RD_LAT - 1);
    end else if (r_state == ST_WAIT) begin
      r_state <= (r_cnt == CNT_W'(1)) ? ST_RESP : ST_WAIT;
      r_cnt   <= r_cnt - CNT_W'(1);
    end else if (r_state == ST_RESP) begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: rtl/dmem_sync.sv
// dmem_sync: byte-enabled synchronous data memory with fixed-latency responses
// Optional build macro DMEM_PRELOAD_EN: reset loads words 0..9 from the preload table.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int SH    = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_pend_data, r_rsp_rdata;
  logic              r_pend_err, r_rsp_err;
  logic              w_accept, w_enter_resp, w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic [IDX_W-1:0]  w_idx_s;
  logic [DATA_W-1:0] w_cur, w_merged, w_rsp_data;
  assign w_idx      = req_addr >> SH;
  assign w_oor      = w_idx >= ADDR_W'(DEPTH);
  assign w_idx_s    = w_idx[IDX_W-1:0];
  assign w_cur      = r_mem[w_idx_s];
  assign w_rsp_data = w_oor ? '0 : (req_we ? w_merged : w_cur);
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  dmem_rsp_timer #(.RD_LAT(RD_LAT)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_accept     (w_accept),
    .o_enter_resp (w_enter_resp)
  );
  // Merge write data into the addressed word lane by lane
  always_comb begin
    w_merged = w_cur;
    for (int b = 0; b < NB; b++) w_merged[8*b +: 8] = req_be[b] ? req_wdata[8*b +: 8] : w_cur[8*b +: 8];
  end
  // Array: reset init, then in-range writes at the acceptance edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_PRELOAD_EN
        r_mem[i] <= DATA_W'(preload_word(i));
`else
        r_mem[i] <= '0;
`endif
      end
    end else if (w_accept && req_we && !w_oor) begin
      r_mem[w_idx_s] <= w_merged;
    end
  end
  // Capture response at acceptance, expose it only when entering RESP so outputs hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_data <= '0;
      r_pend_err  <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_data <= w_rsp_data;
        r_pend_err  <= w_oor;
      end
      if (w_enter_resp) begin
        r_rsp_rdata <= w_accept ? w_rsp_data : r_pend_data;
        r_rsp_err   <= w_accept ? w_oor : r_pend_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_sync.sv
// tb_dmem_sync: randomized checks of dmem_sync (RD_LAT=1 and RD_LAT=3) against a word-array model
module tb_dmem_sync;
  localparam int LAT3 = 3;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v1, v3, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        rdy1, rdy3, rv1, rv3, err1, err3;
  logic [31:0] rd1, rd3;
  logic [31:0] m1 [32];
  logic [31:0] m3 [32];
  logic [31:0] last_rd;
  logic        last_err;
  int          pre_tbl [10] = '{2, 3, 8, 12, 6, 20, 24, 28, 32, 36};
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_sync u_dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we), .req_be(be),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1)
  );
  dmem_sync #(.RD_LAT(LAT3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(we), .req_be(be),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_rdy(input int sel);
    return (sel == 3) ? rdy3 : rdy1;
  endfunction
  function automatic logic f_rv(input int sel);
    return (sel == 3) ? rv3 : rv1;
  endfunction
  function automatic logic [31:0] f_rd(input int sel);
    return (sel == 3) ? rd3 : rd1;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 3) ? err3 : err1;
  endfunction

  function automatic logic [31:0] init_word(input int i);
`ifdef DMEM_PRELOAD_EN
    return (i < 10) ? 32'(pre_tbl[i]) : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m1[i] = init_word(i);
      m3[i] = init_word(i);
    end
  endtask

  task automatic txn(input int sel, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_d;
    logic        exp_e;
    int          idx;
    int          lat;
    idx   = int'(a >> 2);
    exp_e = idx >= 32;
    exp_d = 32'd0;
    if (!exp_e) begin
      exp_d = (sel == 3) ? m3[idx] : m1[idx];
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) exp_d[8*k +: 8] = d[8*k +: 8];
        if (sel == 3) m3[idx] = exp_d;
        else m1[idx] = exp_d;
      end
    end
    @(negedge clk);
    we = w; be = b; addr = a; wdata = d;
    v1 = (sel != 3); v3 = (sel == 3);
    chk("ready_idle", f_rdy(sel), 1);
    @(negedge clk);
    v1 = 0; v3 = 0;
    lat = 1;
    while (!f_rv(sel) && lat < 8) begin
      chk("ready_busy", f_rdy(sel), 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (sel == 3) ? LAT3 : 1);
    chk("ready_resp", f_rdy(sel), 0);
    chk("rdata", f_rd(sel), exp_d);
    chk("err", f_err(sel), exp_e);
    last_rd  = f_rd(sel);
    last_err = f_err(sel);
    @(negedge clk);
    chk("one_pulse", f_rv(sel), 0);
    chk("rdata_hold", f_rd(sel), exp_d);
    chk("err_hold", f_err(sel), exp_e);
    chk("ready_back", f_rdy(sel), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    v1 = 0; v3 = 0; we = 0; be = 0; addr = 0; wdata = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
    chk("rst_rdy1", rdy1, 1);
    chk("rst_rdy3", rdy3, 1);
    chk("rst_rv1", rv1, 0);
    chk("rst_rv3", rv3, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_err3", err3, 0);
`ifdef DMEM_PRELOAD_EN
    txn(1, 0, 4'h0, 32'h14, 32'h0);
    chk("pre_w5", last_rd, 20);
    txn(1, 0, 4'h0, 32'h28, 32'h0);
    chk("pre_w10", last_rd, 0);
`endif
    for (int s = 1; s <= 3; s += 2) begin
      txn(s, 1, 4'hF, 32'h08, 32'h12345678);
      chk("wr_rsp", last_rd, 32'h12345678);
      txn(s, 0, 4'h0, 32'h08, 32'h0);
      chk("rd_rsp", last_rd, 32'h12345678);
      chk("rd_err", last_err, 0);
      txn(s, 1, 4'h5, 32'h08, 32'hAABBCCDD);
      chk("be_merge", last_rd, 32'h12BB56DD);
      txn(s, 0, 4'h0, 32'h0B, 32'h0);
      chk("be_read", last_rd, 32'h12BB56DD);
      txn(s, 1, 4'hF, 32'h80, 32'hFFFFFFFF);
      chk("oor_err", last_err, 1);
      chk("oor_rdata", last_rd, 0);
      txn(s, 1, 4'h0, 32'h08, 32'hFFFFFFFF);
      chk("be_zero", last_rd, 32'h12BB56DD);
    end
    // request held high through the busy window is accepted only once ready returns
    @(negedge clk);
    we = 0; be = 0; addr = 32'h08; v3 = 1;
    chk("hold_rdy0", rdy3, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("hold_rv", rv3, (k == 3 || k == 7));
      chk("hold_rdy", rdy3, (k == 4));
      if (rv3) chk("hold_rd", rd3, m3[2]);
      if (k == 5) v3 = 0;
    end
    @(negedge clk);
    // reset mid-wait drops the response; a request during reset is not taken
    @(negedge clk);
    we = 1; be = 4'hF; addr = 32'h0; wdata = 32'hFFFFFFFF; v3 = 1;
    @(negedge clk);
    v3 = 0; v1 = 1; reset = 1;
    @(negedge clk);
    reset = 0; v1 = 0;
    model_reset();
    chk("mid_rdy3", rdy3, 1);
    chk("mid_rv3", rv3, 0);
    chk("mid_rd3", rd3, 0);
    chk("mid_err3", err3, 0);
    chk("mid_rdy1", rdy1, 1);
    chk("mid_rv1", rv1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_norsp", rv3, 0);
    end
    txn(1, 0, 4'h0, 32'h0, 32'h0);
    txn(3, 0, 4'h0, 32'h0, 32'h0);
    for (int n = 0; n < 80; n++) begin
      txn($urandom_range(0, 1) ? 3 : 1, 1'($urandom_range(0, 1)), 4'($urandom),
          32'($urandom_range(0, 159)), $urandom);
    end
    for (int i = 0; i < 32; i++) begin
      txn(1, 0, 4'h0, 32'(i * 4), 32'h0);
      txn(3, 0, 4'h0, 32'(i * 4 + 1), 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
